// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU command path: widths, op codes and
// the command record carried through the queue.
package alu4_pkg;
  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;
endpackage

// File: rtl/alu4_cmd_queue_if.sv
// Bundle of the command, ALU and result handshakes around alu4_cmd_queue.
interface alu4_cmd_queue_if
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_r;
  logic              alu_zero;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_r;
  logic              out_zero;
  logic [CW-1:0]     count;

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_r, alu_zero, out_ready,
    output in_ready, alu_op, alu_a, alu_b, out_valid, out_r, out_zero, count
  );

  modport master (
    output in_valid, in_op, in_a, in_b, alu_r, alu_zero, out_ready,
    input  in_ready, alu_op, alu_a, alu_b, out_valid, out_r, out_zero, count
  );
endinterface

// File: rtl/alu4_cmd_fifo.sv
// Power-of-two command FIFO; occupancy is counted separately from the
// pointers so full and empty never alias.
module alu4_cmd_fifo
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  cmd_t          din,
  output cmd_t          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  cmd_t          mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage is left unreset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu4_cmd_queue.sv
// Command queue in front of an external combinational ALU, with a single
// result register holding the last issued result until downstream takes it.
module alu4_cmd_queue
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu4_cmd_queue_if.slave  q
);
  localparam int CW = $clog2(DEPTH + 1);

  cmd_t          din, head;
  logic          full, empty, issue;
  logic [CW-1:0] count;

  assign din = '{op: q.in_op, a: q.in_a, b: q.in_b};

  alu4_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q.in_valid && q.in_ready),
    .pop   (issue),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign q.in_ready = !full;
  assign q.count    = count;

  // Head is only shown to the ALU while it is valid so the ALU sees zeros when idle.
  assign q.alu_op = empty ? '0 : head.op;
  assign q.alu_a  = empty ? '0 : head.a;
  assign q.alu_b  = empty ? '0 : head.b;

  assign issue = !empty && (!q.out_valid || q.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.out_valid <= 1'b0;
      q.out_r     <= '0;
      q.out_zero  <= 1'b0;
    end else if (issue) begin
      q.out_valid <= 1'b1;
      q.out_r     <= q.alu_r;
      q.out_zero  <= q.alu_zero;
    end else if (q.out_ready) begin
      q.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu4_cmd_queue.sv
// Directed and randomised checks of alu4_cmd_queue against a behavioural ALU
// and an in-order scoreboard.
module tb_alu4_cmd_queue;
  import alu4_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vec  = 0;
  int   errs = 0;

  alu4_cmd_queue_if #(.DEPTH(4)) q ();

  alu4_cmd_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [3:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~a;
      3'b110:  r = {a[2:0], 1'b0};
      default: r = {1'b0, a[3:1]};
    endcase
    return {(r == 4'h0), r};
  endfunction

  always_comb {q.alu_zero, q.alu_r} = alu_ref(q.alu_op, q.alu_a, q.alu_b);

  task automatic test_reset();
    q.in_valid = 0; q.in_op = 0; q.in_a = 0; q.in_b = 0; q.out_ready = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vec++; if (q.count !== 3'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", q.count); end
    vec++; if (q.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", q.out_valid); end
    vec++; if ({q.out_zero, q.out_r} !== 5'h00) begin errs++; $display("FAIL rst_out_r: got %h want 00", {q.out_zero, q.out_r}); end
    vec++; if ({q.alu_op, q.alu_a, q.alu_b} !== 11'h0) begin errs++; $display("FAIL rst_alu_idle: got %h want 0", {q.alu_op, q.alu_a, q.alu_b}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec++; if (q.in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", q.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    q.out_ready = 1;
    q.in_valid = 1; q.in_op = OP_ADD; q.in_a = 4'd3; q.in_b = 4'd5;
    @(negedge clk);
    q.in_valid = 0;
    vec++; if (q.out_valid !== 1'b0 || q.count !== 3'd1) begin errs++; $display("FAIL basic_edge1: got v=%b c=%0d want v=0 c=1", q.out_valid, q.count); end
    vec++; if ({q.alu_op, q.alu_a, q.alu_b} !== {3'b000, 4'd3, 4'd5}) begin errs++; $display("FAIL basic_head: got %h want %h", {q.alu_op, q.alu_a, q.alu_b}, {3'b000, 4'd3, 4'd5}); end
    @(negedge clk);
    vec++; if (q.out_valid !== 1'b1 || q.out_r !== 4'd8 || q.out_zero !== 1'b0 || q.count !== 3'd0) begin
      errs++; $display("FAIL basic_result: got v=%b r=%h z=%b c=%0d want v=1 r=8 z=0 c=0", q.out_valid, q.out_r, q.out_zero, q.count);
    end
    @(negedge clk);
    vec++; if (q.out_valid !== 1'b0 || q.out_r !== 4'd8) begin errs++; $display("FAIL basic_drain: got v=%b r=%h want v=0 r=8", q.out_valid, q.out_r); end
  endtask

  task automatic test_ops();
    logic [15:0] tbl [8] = '{
      {3'b001, 4'h5, 4'h5, 1'b1, 4'h0},   // SUB 5-5
      {3'b110, 4'h9, 4'h7, 1'b0, 4'h2},   // SHL 9
      {3'b010, 4'hC, 4'hA, 1'b0, 4'h8},   // AND
      {3'b011, 4'h5, 4'hA, 1'b0, 4'hF},   // OR
      {3'b100, 4'hF, 4'hF, 1'b1, 4'h0},   // XOR
      {3'b101, 4'h0, 4'h3, 1'b0, 4'hF},   // NOT
      {3'b111, 4'h9, 4'h1, 1'b0, 4'h4},   // SHR
      {3'b000, 4'hF, 4'h1, 1'b1, 4'h0}    // ADD wraps
    };
    q.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] t;
      t = tbl[i];
      q.in_valid = 1; q.in_op = t[15:13]; q.in_a = t[12:9]; q.in_b = t[8:5];
      @(negedge clk);
      q.in_valid = 0;
      @(negedge clk);
      vec++; if (q.out_valid !== 1'b1 || {q.out_zero, q.out_r} !== t[4:0]) begin
        errs++; $display("FAIL ops_%0d: got v=%b zr=%h want v=1 zr=%h", i, q.out_valid, {q.out_zero, q.out_r}, t[4:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [3:0] expv [5] = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA};
    int acc = 0, got = 0;
    q.out_ready = 0;
    for (int c = 0; c < 8; c++) begin
      q.in_valid = 1; q.in_op = OP_ADD; q.in_a = 4'(acc + 1); q.in_b = 4'(acc + 1);
      if (q.in_ready) acc++;
      @(negedge clk);
    end
    q.in_valid = 0;
    vec++; if (acc != 5) begin errs++; $display("FAIL fill_accepted: got %0d want 5", acc); end
    vec++; if (q.in_ready !== 1'b0 || q.count !== 3'd4 || q.out_valid !== 1'b1) begin
      errs++; $display("FAIL fill_full: got rdy=%b c=%0d v=%b want rdy=0 c=4 v=1", q.in_ready, q.count, q.out_valid);
    end
    q.out_ready = 1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (q.out_valid) begin
        vec++; if (q.out_r !== expv[got]) begin errs++; $display("FAIL fill_order_%0d: got %h want %h", got, q.out_r, expv[got]); end
        got++;
      end
      @(negedge clk);
    end
    vec++; if (got != 5 || q.out_valid !== 1'b0 || q.count !== 3'd0) begin
      errs++; $display("FAIL fill_drain: got n=%0d v=%b c=%0d want n=5 v=0 c=0", got, q.out_valid, q.count);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_q [$];
    int sent = 0, got = 0, first = -1, last = -1;
    q.out_ready = 1;
    for (int c = 0; c < 40; c++) begin
      if (sent < 16) begin
        q.in_valid = 1; q.in_op = 3'($urandom_range(0, 7));
        q.in_a = 4'($urandom_range(0, 15)); q.in_b = 4'($urandom_range(0, 15));
        if (q.in_ready) begin exp_q.push_back(alu_ref(q.in_op, q.in_a, q.in_b)); sent++; end
      end else q.in_valid = 0;
      if (q.out_valid) begin
        vec++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL b2b_extra: got %h want none", {q.out_zero, q.out_r}); end
        else begin
          if ({q.out_zero, q.out_r} !== exp_q[0]) begin errs++; $display("FAIL b2b_%0d: got %h want %h", got, {q.out_zero, q.out_r}, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        if (first < 0) first = c;
        last = c; got++;
      end
      @(negedge clk);
    end
    vec++; if (got != 16 || last - first != 15) begin
      errs++; $display("FAIL b2b_rate: got n=%0d span=%0d want n=16 span=15", got, last - first);
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_q [$];
    logic [4:0] hold_v;
    bit hold = 0;
    int sent = 0, got = 0;
    for (int c = 0; c < 1100; c++) begin
      if (hold) begin
        vec++; if (q.out_valid !== 1'b1 || {q.out_zero, q.out_r} !== hold_v) begin
          errs++; $display("FAIL rnd_hold_%0d: got v=%b zr=%h want v=1 zr=%h", c, q.out_valid, {q.out_zero, q.out_r}, hold_v);
        end
      end
      if (c < 1000) begin
        q.in_valid = ($urandom_range(0, 9) < 6); q.out_ready = 1'($urandom_range(0, 1));
        q.in_op = 3'($urandom_range(0, 7));
        q.in_a = 4'($urandom_range(0, 15)); q.in_b = 4'($urandom_range(0, 15));
      end else begin
        q.in_valid = 0; q.out_ready = 1;
      end
      if (q.in_valid && q.in_ready) begin exp_q.push_back(alu_ref(q.in_op, q.in_a, q.in_b)); sent++; end
      if (q.out_valid && q.out_ready) begin
        vec++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL rnd_extra: got %h want none", {q.out_zero, q.out_r}); end
        else begin
          if ({q.out_zero, q.out_r} !== exp_q[0]) begin errs++; $display("FAIL rnd_%0d: got %h want %h", got, {q.out_zero, q.out_r}, exp_q[0]); end
          void'(exp_q.pop_front());
          got++;
        end
      end
      hold = q.out_valid && !q.out_ready;
      hold_v = {q.out_zero, q.out_r};
      @(negedge clk);
    end
    vec++; if (got != sent || exp_q.size() != 0) begin
      errs++; $display("FAIL rnd_loss: got delivered=%0d want %0d", got, sent);
    end
  endtask

  task automatic test_reset_mid();
    q.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      q.in_valid = 1; q.in_op = OP_OR; q.in_a = 4'(i + 1); q.in_b = 4'h0;
      @(negedge clk);
    end
    q.in_valid = 0;
    vec++; if (q.count !== 3'd3 || q.out_valid !== 1'b1) begin
      errs++; $display("FAIL mid_prefill: got c=%0d v=%b want c=3 v=1", q.count, q.out_valid);
    end
    rst_n = 1'b0;
    #1;
    vec++; if (q.count !== 3'd0 || q.out_valid !== 1'b0 || q.out_r !== 4'h0) begin
      errs++; $display("FAIL mid_reset: got c=%0d v=%b r=%h want c=0 v=0 r=0", q.count, q.out_valid, q.out_r);
    end
    @(negedge clk);
    rst_n = 1'b1; q.out_ready = 1;
    q.in_valid = 1; q.in_op = OP_ADD; q.in_a = 4'd6; q.in_b = 4'd7;
    @(negedge clk);
    q.in_valid = 0;
    vec++; if (q.out_valid !== 1'b0) begin errs++; $display("FAIL mid_lat1: got v=%b want 0", q.out_valid); end
    @(negedge clk);
    vec++; if (q.out_valid !== 1'b1 || q.out_r !== 4'hD || q.out_zero !== 1'b0) begin
      errs++; $display("FAIL mid_result: got v=%b r=%h z=%b want v=1 r=d z=0", q.out_valid, q.out_r, q.out_zero);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/alu4_cmd_queue.md
ALU4_CMD_QUEUE -- requirements
Module: alu4_cmd_queue

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  block can accept a command this cycle.
REQ-006 in_op  input  3  ALU operation code.
REQ-007 in_a  input  4  operand A.
REQ-008 in_b  input  4  operand B.
REQ-009 alu_op  output  3  op code driven to the combinational ALU.
REQ-010 alu_a  output  4  operand A driven to the ALU.
REQ-011 alu_b  output  4  operand B driven to the ALU.
REQ-012 alu_r  input  4  ALU result, same-cycle combinational response to alu_*.
REQ-013 alu_zero  input  1  ALU zero flag, same-cycle.
REQ-014 out_valid  output  1  result register holds an undelivered result.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_r  output  4  registered result.
REQ-017 out_zero  output  1  registered zero flag.
REQ-018 count  output  3  FIFO occupancy, 0..DEPTH (excludes result register).

Function
REQ-019 Accept: command enqueued at a rising edge where in_valid && in_ready.
REQ-020 in_ready SHALL be 1 exactly when count < DEPTH; no full-queue bypass.
REQ-021 alu_op/alu_a/alu_b SHALL combinationally present the FIFO head when count > 0, and 3'b000/4'h0/4'h0 when empty.
REQ-022 Issue condition: count > 0 && (!out_valid || out_ready); at that edge head is popped and alu_r/alu_zero captured into out_r/out_zero, out_valid set to 1.
REQ-023 If out_valid && out_ready and no issue occurs, out_valid SHALL clear at that edge; out_r/out_zero hold their last values.
REQ-024 If out_valid && !out_ready, out_valid/out_r/out_zero SHALL hold unchanged and no pop occurs.
REQ-025 Latency: command accepted at edge N with empty queue and empty result register -> out_valid high after edge N+1.
REQ-026 Throughput: one command per cycle sustained when out_ready held high.
REQ-027 Simultaneous push and pop in one edge: count unchanged; FIFO order preserved; allowed even when count == DEPTH only if in_ready was high (it is not, per REQ-020).
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; count tracked separately so full and empty are unambiguous.
REQ-029 Results SHALL be delivered in strict command acceptance order; no command dropped or duplicated.
REQ-030 Maximum in-flight commands: DEPTH + 1 (FIFO plus result register).

Reset
REQ-031 On rst_n low: count=0, pointers=0, out_valid=0, out_r=4'h0, out_zero=0, immediately and asynchronously.
REQ-032 Reset mid-operation SHALL discard all queued and undelivered commands; FIFO storage contents need no reset.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 on the first cycle.

Structure
REQ-034 Shared package alu4_pkg SHALL hold DATA_W=4, OP_W=3, op-code constants (ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101, SHL 110, SHR 111) and the command record {op, a, b}.
REQ-035 FIFO SHALL be a sub-module alu4_cmd_fifo (push/pop/full/empty/count, parameter DEPTH); handshake and result register in the top.
REQ-036 The ALU itself SHALL remain outside this block; connection only via alu_* ports.

Verification (bench models ALU per alu4_pkg op codes)
REQ-037 Push {ADD,3,5}, out_ready=1 -> out_valid after 2 edges, out_r=8, out_zero=0.
REQ-038 Push {SUB,5,5} -> out_r=0, out_zero=1; push {SHL,4'h9,x} -> out_r=2, out_zero=0.
REQ-039 out_ready=0, in_valid=1 continuous -> exactly 5 commands accepted, then in_ready=0, count=4; raise out_ready -> 5 results in order.
REQ-040 Back-to-back 16 random commands, out_ready=1 -> one result per cycle after fill, all match model, in order.
REQ-041 Random out_ready toggling with random in_valid over 1000 cycles -> no loss, no reorder, out_r stable while out_valid && !out_ready.
REQ-042 Assert rst_n low with count=3 and out_valid=1 -> out_valid=0, count=0 same cycle; next command yields correct result with latency 2.
